// File: rtl/uart_fifo_bridge_pkg.sv
// Shared register map, status bit positions and the handshake state type
// used by the UART FIFO bridge.
package uart_fifo_bridge_pkg;

  localparam logic [7:0] UART_DATA = 8'h10;
  localparam logic [7:0] UART_STAT = 8'h14;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_RX_NONEMPTY  = 1;
  localparam int ST_TX_EMPTY     = 2;
  localparam int ST_RX_UNDERRUN  = 3;
  localparam int ST_TX_OVERRUN   = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_COUNT_LSB = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_GAP  = 1'b1
  } xfer_state_t;

endpackage

// File: rtl/uart_fifo_bridge_sync_fifo.sv
// Single-clock FIFO with combinational head read. A push into a full FIFO
// succeeds only when a pop happens in the same cycle; a pop on empty is ignored.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage is deliberately unreset so it maps onto LUT RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Memory-mapped UART buffer: CPU registers 0x10/0x14, TX drain and RX fill FSMs.
//   state  | meaning
//   S_IDLE | waiting for work (TX: data queued and core idle; RX: byte offered and room)
//   S_GAP  | one-cycle pause after a handshake so busy can rise / rx_valid can drop
module uart_fifo_bridge
  import uart_fifo_bridge_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_sel,
  input  logic [7:0]  bus_addr,
  input  logic [3:0]  bus_wstrb,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_read,
  output logic        irq
);

  logic wr, rd, data_hit, stat_hit;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic [AW:0] tx_count, rx_count;
  logic        rx_underrun, tx_overrun;
  logic [31:0] status, rd_value;
  logic        unused_wdata;
  xfer_state_t tx_state, tx_state_nxt, rx_state, rx_state_nxt;

  assign wr           = bus_sel && bus_wstrb[0];
  assign rd           = bus_sel && (bus_wstrb == 4'h0);
  assign data_hit     = (bus_addr == UART_DATA);
  assign stat_hit     = (bus_addr == UART_STAT);
  assign tx_push      = wr && data_hit;
  assign rx_pop       = rd && data_hit;
  assign irq          = !rx_empty || rx_underrun || tx_overrun;
  assign unused_wdata = ^bus_wdata[31:8];

  sync_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(bus_wdata[7:0]), .pop(tx_pop),
    .dout(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.DEPTH(DEPTH), .AW(AW), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_data), .pop(rx_pop),
    .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= S_IDLE;
      rx_state <= S_IDLE;
    end else begin
      tx_state <= tx_state_nxt;
      rx_state <= rx_state_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    rx_state_nxt = rx_state;
    case (tx_state)
      S_IDLE:  if (tx_pop) tx_state_nxt = S_GAP;
      default: tx_state_nxt = S_IDLE;
    endcase
    case (rx_state)
      S_IDLE:  if (rx_push) rx_state_nxt = S_GAP;
      default: rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = (tx_state == S_IDLE) && !tx_empty && !tx_busy;
    rx_push = (rx_state == S_IDLE) && rx_valid && !rx_full;
  end

  // Handshake outputs are registered; the FIFO pop/push happens on the decision edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en   <= 1'b0;
      tx_data <= '0;
      rx_read <= 1'b0;
    end else begin
      tx_en   <= tx_pop;
      rx_read <= rx_push;
      if (tx_pop) tx_data <= tx_head;
    end
  end

  always_comb begin
    status                          = '0;
    status[ST_TX_FULL]              = tx_full;
    status[ST_RX_NONEMPTY]          = !rx_empty;
    status[ST_TX_EMPTY]             = tx_empty;
    status[ST_RX_UNDERRUN]          = rx_underrun;
    status[ST_TX_OVERRUN]           = tx_overrun;
    status[ST_RX_COUNT_LSB +: 8]    = 8'(rx_count);
    status[ST_TX_COUNT_LSB +: 8]    = 8'(tx_count);
    rd_value = '0;
    if (data_hit)      rd_value[7:0] = rx_empty ? 8'h00 : rx_head;
    else if (stat_hit) rd_value      = status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_rdata   <= '0;
      rx_underrun <= 1'b0;
      tx_overrun  <= 1'b0;
    end else begin
      bus_rdata <= rd ? rd_value : '0;
      if (tx_push && tx_full && !tx_pop)
        tx_overrun <= 1'b1;
      else if (wr && stat_hit && bus_wdata[ST_TX_OVERRUN])
        tx_overrun <= 1'b0;
      if (rx_pop && rx_empty)
        rx_underrun <= 1'b1;
      else if (wr && stat_hit && bus_wdata[ST_RX_UNDERRUN])
        rx_underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: queue-based model of both FIFOs and simple
// uart_tx / uart_rx core models.
module tb_uart_fifo_bridge;

  localparam int DEPTH = 16;
  localparam logic [7:0] A_DATA = 8'h10;
  localparam logic [7:0] A_STAT = 8'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel;
  logic [7:0]  bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_read;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  logic [7:0] sent_q[$];
  logic [7:0] src_q[$];
  int         src_idx = 0;
  int         src_end = 0;
  logic [7:0] acc_q[$];
  int         rd_idx = 0;
  int         rx_reads = 0;
  int         busy_viol = 0;
  int         full_viol = 0;
  logic       m_urun = 1'b0;
  logic       m_orun = 1'b0;

  always #5 clk = ~clk;
  assign tx_busy = hold_busy || (busy_cnt != 0);

  uart_fifo_bridge #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .rst(rst), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_read(rx_read), .irq(irq)
  );

  // uart_tx: busy for 10 cycles per byte. uart_rx: offers src_q bytes in order.
  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (tx_en) begin
          if (tx_busy) busy_viol++;
          sent_q.push_back(tx_data);
          busy_cnt = 10;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        if (rx_read) begin
          rx_reads++;
          if (acc_q.size() - rd_idx >= DEPTH) full_viol++;
          if (src_idx < src_end) begin
            acc_q.push_back(src_q[src_idx]);
            src_idx++;
          end
        end
      end
      rx_valid = (src_idx < src_end);
      rx_data  = rx_valid ? src_q[src_idx] : 8'h00;
    end
  end

  function automatic logic [31:0] exp_stat(input int txc);
    int rxc;
    logic [31:0] s;
    rxc = acc_q.size() - rd_idx;
    s = (32'(rxc) << 8) | (32'(txc) << 16);
    if (txc == DEPTH) s |= 32'h01;
    if (rxc > 0)      s |= 32'h02;
    if (txc == 0)     s |= 32'h04;
    if (m_urun)       s |= 32'h08;
    if (m_orun)       s |= 32'h10;
    return s;
  endfunction

  function automatic logic [31:0] model_rx_pop();
    logic [31:0] e;
    if (rd_idx < acc_q.size()) begin
      e = {24'h0, acc_q[rd_idx]};
      rd_idx++;
    end else begin
      e = 32'h0;
      m_urun = 1'b1;
    end
    return e;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_addr = a; bus_wstrb = 4'hF; bus_wdata = d;
    @(negedge clk);
    bus_sel = 1'b0; bus_wstrb = 4'h0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_sel = 1'b1; bus_addr = a; bus_wstrb = 4'h0;
    @(negedge clk);
    bus_sel = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_sent(input int n, input int budget);
    int k = 0;
    while (sent_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sent_q.size() < n) begin
      errors++;
      $display("FAIL tx_timeout: sent %0d bytes, required %0d", sent_q.size(), n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_rdata, tx_data, tx_en, rx_read, irq} !== 43'h0) begin
      errors++;
      $display("FAIL reset_outputs: rdata=%h txd=%h en=%b rd=%b irq=%b, required all 0",
               bus_rdata, tx_data, tx_en, rx_read, irq);
    end
    rst = 1'b0;
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL reset_status: got %h required %h", d, exp_stat(0));
    end
    bus_read(8'h20, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL unmapped_read: got %h required 0", d);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b required 0", irq);
    end
  endtask

  task automatic test_tx_order();
    logic [31:0] d;
    int base = sent_q.size();
    logic [7:0] bytes[3] = '{8'h41, 8'h42, 8'h43};
    foreach (bytes[i]) bus_write(A_DATA, {24'h0, bytes[i]});
    wait_sent(base + 3, 200);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sent_q.size() > base + i && sent_q[base + i] !== bytes[i]) begin
        errors++; $display("FAIL tx_order[%0d]: got %h required %h", i, sent_q[base + i], bytes[i]);
      end
    end
    repeat (12) @(negedge clk);
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL tx_drained_status: got %h required %h", d, exp_stat(0));
    end
  endtask

  task automatic test_tx_overrun();
    logic [31:0] d;
    logic [7:0] wr_q[$];
    logic [7:0] extra;
    int base;
    repeat (12) @(negedge clk);
    base = sent_q.size();
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) begin
      wr_q.push_back(8'($urandom));
      bus_write(A_DATA, {$urandom, wr_q[i]});
    end
    m_orun = 1'b1;
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(DEPTH) || d !== 32'h0010_0011) begin
      errors++; $display("FAIL overrun_status: got %h required %h", d, exp_stat(DEPTH));
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL overrun_irq: got %b required 1", irq);
    end
    bus_write(A_STAT, 32'h10);
    m_orun = 1'b0;
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(DEPTH)) begin
      errors++; $display("FAIL overrun_w1c: got %h required %h", d, exp_stat(DEPTH));
    end
    // Release the core and write in the same cycle the drain pops from the full FIFO.
    extra = 8'($urandom);
    @(negedge clk);
    hold_busy = 1'b0;
    bus_sel = 1'b1; bus_addr = A_DATA; bus_wstrb = 4'h1; bus_wdata = {24'h0, extra};
    @(negedge clk);
    bus_sel = 1'b0; bus_wstrb = 4'h0;
    wait_sent(base + DEPTH + 1, 400);
    for (int i = 0; i <= DEPTH; i++) begin
      logic [7:0] e;
      e = (i == DEPTH) ? extra : wr_q[i];
      checks++;
      if (sent_q.size() > base + i && sent_q[base + i] !== e) begin
        errors++; $display("FAIL tx_full_drain[%0d]: got %h required %h", i, sent_q[base + i], e);
      end
    end
    repeat (12) @(negedge clk);
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL full_push_pop_status: got %h required %h", d, exp_stat(0));
    end
  endtask

  task automatic test_rx();
    logic [31:0] d, e;
    int r0 = rx_reads;
    int k = 0;
    src_q.push_back(8'h55); src_q.push_back(8'hAA); src_end = src_q.size();
    while (rx_reads < r0 + 2 && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_reads - r0 !== 2) begin
      errors++; $display("FAIL rx_read_pulses: got %0d required 2", rx_reads - r0);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL rx_irq: got %b required 1", irq);
    end
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL rx_status: got %h required %h", d, exp_stat(0));
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(A_DATA, d);
      e = model_rx_pop();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL rx_data[%0d]: got %h required %h", i, d, e);
      end
    end
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0) || irq !== 1'b1) begin
      errors++; $display("FAIL underrun_status: got %h irq=%b required %h irq=1", d, irq, exp_stat(0));
    end
    bus_write(A_STAT, 32'h08);
    m_urun = 1'b0;
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0) || irq !== 1'b0) begin
      errors++; $display("FAIL underrun_w1c: got %h irq=%b required %h irq=0", d, irq, exp_stat(0));
    end
  endtask

  task automatic test_rx_full_and_reset();
    logic [31:0] d, e;
    int r0 = rx_reads;
    for (int i = 0; i < DEPTH + 4; i++) src_q.push_back(8'($urandom));
    src_end = src_q.size();
    repeat (80) @(negedge clk);
    checks++;
    if (rx_reads - r0 !== DEPTH) begin
      errors++; $display("FAIL rx_fill_pulses: got %0d required %0d", rx_reads - r0, DEPTH);
    end
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL rx_full_status: got %h required %h", d, exp_stat(0));
    end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d);
      e = model_rx_pop();
      checks++;
      if (d !== e) begin
        errors++; $display("FAIL rx_full_data[%0d]: got %h required %h", i, d, e);
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rx_reads - r0 !== DEPTH + 4 || full_viol !== 0) begin
      errors++; $display("FAIL rx_refill: got %0d pulses %0d while full, required %0d and 0",
                         rx_reads - r0, full_viol, DEPTH + 4);
    end
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL rx_refill_status: got %h required %h", d, exp_stat(0));
    end
    for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'($urandom));
    src_q.push_back(8'hC3); src_end = src_q.size();
    bus_read(A_DATA, d);
    e = model_rx_pop();
    @(negedge clk);
    rst = 1'b1;
    src_end = src_idx;
    rd_idx = acc_q.size();
    m_urun = 1'b0; m_orun = 1'b0;
    #1;
    checks++;
    if ({bus_rdata, tx_data, tx_en, rx_read, irq} !== 43'h0) begin
      errors++; $display("FAIL midstream_reset: rdata=%h txd=%h en=%b rd=%b irq=%b, required all 0",
                         bus_rdata, tx_data, tx_en, rx_read, irq);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, d);
    checks++;
    if (d !== exp_stat(0)) begin
      errors++; $display("FAIL post_reset_status: got %h required %h", d, exp_stat(0));
    end
    checks++;
    if (busy_viol !== 0) begin
      errors++; $display("FAIL tx_en_while_busy: got %0d required 0", busy_viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus_sel = 1'b0; bus_addr = 8'h00; bus_wstrb = 4'h0; bus_wdata = 32'h0;
    test_reset();
    test_tx_order();
    test_tx_overrun();
    test_rx();
    test_rx_full_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
